// File: rtl/y86_defs_pkg.sv
// ----------------------------------------------------------------------------
// y86_defs : shared Y86-64 pipeline definitions.
//   Register index width, the RNONE "no register" encoding, register index
//   names (%rax..%r14), the %rsp index, its reset value, and the instruction
//   codes used by the other pipeline stages.
// No ports (package).
// ----------------------------------------------------------------------------
package y86_defs;

    localparam int unsigned ADDR_W     = 4;
    localparam logic [3:0]  RNONE      = 4'hF;
    localparam int unsigned RSP_IDX    = 4;
    localparam logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200;

    typedef enum logic [3:0] {
        RRAX = 4'h0,
        RRCX = 4'h1,
        RRDX = 4'h2,
        RRBX = 4'h3,
        RRSP = 4'h4,
        RRBP = 4'h5,
        RRSI = 4'h6,
        RRDI = 4'h7,
        RR8  = 4'h8,
        RR9  = 4'h9,
        RR10 = 4'hA,
        RR11 = 4'hB,
        RR12 = 4'hC,
        RR13 = 4'hD,
        RR14 = 4'hE,
        RREG_NONE = 4'hF
    } y86_reg_e;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } y86_icode_e;

endpackage

// File: rtl/y86_rf_read_port.sv
// ----------------------------------------------------------------------------
// y86_rf_read_port : one combinational read port of the Y86-64 register file.
//   Selects regs_i[idx_i]; indices >= NREG (including RNONE) read as 0.
//   With BYPASS=1 and wb_en_i=1, an index matching a valid incoming write
//   destination returns the incoming data instead (M port has priority).
//   The top sets BYPASS from the REGFILE_BYPASS_EN macro; the debug port
//   always uses BYPASS=0.
// Ports:
//   idx_i     read index
//   regs_i    stored register contents
//   wb_en_i   write-back enable (qualifies bypass)
//   dstE_i/valE_i, dstM_i/valM_i   incoming write destinations/data
//   data_o    read data
// ----------------------------------------------------------------------------
module y86_rf_read_port
    import y86_defs::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 15,
    parameter int unsigned ADDR_W = 4,
    parameter bit          BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] regs_i [NREG],
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [ADDR_W-1:0] dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [ADDR_W-1:0] RNONE_L = {ADDR_W{1'b1}};

    function automatic logic idx_ok(input logic [ADDR_W-1:0] i);
        return (int'(i) < int'(NREG)) && (i != RNONE_L);
    endfunction

    always_comb begin
        data_o = '0;
        if (idx_ok(idx_i)) begin
            data_o = regs_i[idx_i];
        end
        // E is applied first so a matching M overrides it.
        if (BYPASS && wb_en_i && idx_ok(idx_i)) begin
            if (idx_ok(dstE_i) && (dstE_i == idx_i)) begin
                data_o = valE_i;
            end
            if (idx_ok(dstM_i) && (dstM_i == idx_i)) begin
                data_o = valM_i;
            end
        end
    end

endmodule

// File: rtl/y86_regfile_2w2r.sv
// ----------------------------------------------------------------------------
// y86_regfile_2w2r : Y86-64 register file for the pipelined core.
//   Two combinational read ports (A, B) for decode, two write ports (E, M)
//   for write-back, a debug read port and a committed-write counter.
//   Optional macro REGFILE_BYPASS_EN: when defined, read ports A/B return
//   same-cycle write-back data for matching indices; dbg_val never bypasses.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   wb_en               0 = W stage stalled/bubble, no writes
//   dstE/valE           E write port (RNONE = no write)
//   dstM/valM           M write port (RNONE = no write), wins over E
//   srcA/valA, srcB/valB read ports
//   dbg_idx/dbg_val     debug read port
//   wr_cnt              registers written since reset (wraps)
// ----------------------------------------------------------------------------
module y86_regfile_2w2r
    import y86_defs::*;
#(
    parameter int unsigned              DATA_W     = 64,
    parameter int unsigned              NREG       = 15,
    parameter int unsigned              ADDR_W     = y86_defs::ADDR_W,
    parameter int unsigned              RSP_IDX    = y86_defs::RSP_IDX,
    parameter logic [DATA_W-1:0]        STACK_INIT = DATA_W'(y86_defs::STACK_INIT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_val,
    output logic [31:0]       wr_cnt
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] RNONE_L = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [31:0]       wr_cnt_q;
    logic [31:0]       wr_cnt_d;
    logic              e_wr;
    logic              m_wr;

    function automatic logic dst_ok(input logic [ADDR_W-1:0] d);
        return (int'(d) < int'(NREG)) && (d != RNONE_L);
    endfunction

    // When both ports target the same register only M lands, and the
    // counter sees a single write.
    assign m_wr = wb_en && dst_ok(dstM);
    assign e_wr = wb_en && dst_ok(dstE) && !(m_wr && (dstE == dstM));

    always_comb begin
        regs_d = regs_q;
        if (e_wr) begin
            regs_d[dstE] = valE;
        end
        if (m_wr) begin
            regs_d[dstM] = valM;
        end
        wr_cnt_d = wr_cnt_q + {31'b0, e_wr} + {31'b0, m_wr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= (i == int'(RSP_IDX)) ? STACK_INIT : '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

    y86_rf_read_port #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port_a (
        .idx_i(srcA), .regs_i(regs_q), .wb_en_i(wb_en),
        .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
        .data_o(valA)
    );

    y86_rf_read_port #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port_b (
        .idx_i(srcB), .regs_i(regs_q), .wb_en_i(wb_en),
        .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
        .data_o(valB)
    );

    y86_rf_read_port #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .BYPASS(1'b0)
    ) u_port_dbg (
        .idx_i(dbg_idx), .regs_i(regs_q), .wb_en_i(wb_en),
        .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
        .data_o(dbg_val)
    );

endmodule
